// File: rtl/i2c_sensor_poller.sv
// Command sequencer for an I2C master: one config write after enable, then a
// periodic pointer-write / two-byte read loop with bounded retry and fault latch.
module i2c_sensor_poller #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
  parameter logic [7:0]  CFG_REG     = 8'h01,
  parameter logic [7:0]  CFG_VALUE   = 8'h60,
  parameter logic [7:0]  RESULT_REG  = 8'h00,
  parameter logic [15:0] PERIOD      = 16'd50000,
  parameter logic [1:0]  MAX_RETRIES = 2'd3,
  parameter logic [15:0] TIMEOUT     = 16'd4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        i2c_ready,
  input  logic        i2c_ack,
  input  logic [15:0] i2c_read_data,
  output logic        i2c_start,
  output logic [6:0]  i2c_addr,
  output logic [15:0] i2c_data,
  output logic        i2c_rw,
  output logic        i2c_two_bytes,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        fault,
  output logic [7:0]  nack_count,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_ISSUE, S_CFG_WAIT, S_PTR_ISSUE, S_PTR_WAIT,
    S_RD_ISSUE, S_RD_WAIT, S_SLEEP, S_FAULT
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  state_t      w_wait_state;
  state_t      w_retry_state;
  state_t      w_ok_state;
  logic        r_start;
  logic [15:0] r_data;
  logic        r_rw;
  logic        r_two_bytes;
  logic [15:0] r_sample;
  logic        r_sample_valid;
  logic [7:0]  r_nack_count;
  logic [1:0]  r_retries;
  logic [15:0] r_timer;
  logic        r_seen_busy;
  logic        w_issue;
  logic        w_in_wait;
  logic        w_done;
  logic        w_timeout;
  logic        w_success;
  logic        w_fail;
  logic        w_can_retry;
  logic        w_sleep_done;

  assign w_in_wait    = (r_state == S_CFG_WAIT) || (r_state == S_PTR_WAIT) || (r_state == S_RD_WAIT);
  assign w_done       = r_seen_busy && i2c_ready;
  assign w_timeout    = (r_timer >= (TIMEOUT - 16'd1));
  assign w_success    = w_in_wait && w_done && i2c_ack;
  assign w_fail       = w_in_wait && ((w_done && !i2c_ack) || (!w_done && w_timeout));
  assign w_can_retry  = (r_retries < MAX_RETRIES);
  assign w_sleep_done = (r_timer >= (PERIOD - 16'd1));

  // Per-step mapping shared by the ISSUE and WAIT states of each transaction.
  always_comb begin
    w_wait_state  = S_CFG_WAIT;
    w_retry_state = S_CFG_ISSUE;
    w_ok_state    = S_PTR_ISSUE;
    case (r_state)
      S_PTR_ISSUE, S_PTR_WAIT: begin
        w_wait_state  = S_PTR_WAIT;
        w_retry_state = S_PTR_ISSUE;
        w_ok_state    = S_RD_ISSUE;
      end
      S_RD_ISSUE, S_RD_WAIT: begin
        w_wait_state  = S_RD_WAIT;
        w_retry_state = S_RD_ISSUE;
        w_ok_state    = S_SLEEP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: if (enable) w_state_next = S_CFG_ISSUE;
      S_CFG_ISSUE, S_PTR_ISSUE, S_RD_ISSUE: begin
        if (!enable) begin
          w_state_next = S_IDLE;
        end else if (i2c_ready) begin
          w_issue      = 1'b1;
          w_state_next = w_wait_state;
        end
      end
      // A WAIT always runs to completion; enable is only honoured afterwards.
      S_CFG_WAIT, S_PTR_WAIT, S_RD_WAIT: begin
        if (w_success || w_fail) begin
          if (w_fail && !w_can_retry) w_state_next = S_FAULT;
          else if (!enable)           w_state_next = S_IDLE;
          else if (w_fail)            w_state_next = w_retry_state;
          else                        w_state_next = w_ok_state;
        end
      end
      S_SLEEP: begin
        if (!enable)           w_state_next = S_IDLE;
        else if (w_sleep_done) w_state_next = S_PTR_ISSUE;
      end
      S_FAULT: if (!enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start        <= 1'b0;
      r_data         <= 16'h0000;
      r_rw           <= 1'b0;
      r_two_bytes    <= 1'b0;
      r_sample       <= 16'h0000;
      r_sample_valid <= 1'b0;
      r_nack_count   <= 8'd0;
      r_retries      <= 2'd0;
      r_timer        <= 16'd0;
      r_seen_busy    <= 1'b0;
    end else begin
      r_start        <= w_issue;
      r_sample_valid <= 1'b0;

      // Timer and busy flag restart on every state change, so each WAIT/SLEEP starts at zero.
      if (w_state_next != r_state) begin
        r_timer     <= 16'd0;
        r_seen_busy <= 1'b0;
      end else begin
        if (w_in_wait || (r_state == S_SLEEP)) r_timer <= r_timer + 16'd1;
        if (w_in_wait && !i2c_ready)           r_seen_busy <= 1'b1;
      end

      case (w_state_next)
        S_CFG_ISSUE: begin
          r_data      <= {CFG_REG, CFG_VALUE};
          r_rw        <= 1'b0;
          r_two_bytes <= 1'b1;
        end
        S_PTR_ISSUE: begin
          r_data      <= {8'h00, RESULT_REG};
          r_rw        <= 1'b0;
          r_two_bytes <= 1'b0;
        end
        S_RD_ISSUE: begin
          r_data      <= 16'h0000;
          r_rw        <= 1'b1;
          r_two_bytes <= 1'b1;
        end
        default: ;
      endcase

      if ((w_state_next == S_IDLE) || w_success) r_retries <= 2'd0;
      else if (w_fail && w_can_retry)            r_retries <= r_retries + 2'd1;

      if (w_fail && (r_nack_count != 8'hFF)) r_nack_count <= r_nack_count + 8'd1;

      if (w_success && (r_state == S_RD_WAIT)) begin
        r_sample       <= i2c_read_data;
        r_sample_valid <= 1'b1;
      end
    end
  end

  assign i2c_start     = r_start;
  assign i2c_addr      = SLAVE_ADDR;
  assign i2c_data      = r_data;
  assign i2c_rw        = r_rw;
  assign i2c_two_bytes = r_two_bytes;
  assign sample        = r_sample;
  assign sample_valid  = r_sample_valid;
  assign fault         = (r_state == S_FAULT);
  assign nack_count    = r_nack_count;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_sensor_poller.sv
// Scoreboard bench for i2c_sensor_poller: a behavioural I2C master answers each start,
// expected transactions/samples are queued by the stimulus and checked by a monitor.
module tb_i2c_sensor_poller;

  localparam logic [31:0] CFG_T = {7'd0, 7'h48, 1'b0, 1'b1, 16'h0160};
  localparam logic [31:0] PTR_T = {7'd0, 7'h48, 1'b0, 1'b0, 16'h0000};
  localparam logic [31:0] RD_T  = {7'd0, 7'h48, 1'b1, 1'b1, 16'h0000};

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        m_ready;
  logic        m_ack;
  logic [15:0] rd_val = 16'h1A2B;
  logic        i2c_start;
  logic [6:0]  i2c_addr;
  logic [15:0] i2c_data;
  logic        i2c_rw;
  logic        i2c_two_bytes;
  logic [15:0] sample;
  logic        sample_valid;
  logic        fault;
  logic [7:0]  nack_count;
  logic        busy;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  chk_t        chk_q[$];
  logic [31:0] exp_txn[$];
  logic [15:0] exp_sample[$];

  int   n_checks       = 0;
  int   n_pass         = 0;
  int   cyc            = 0;
  int   n_starts       = 0;
  int   n_samples      = 0;
  int   last_start_cyc = 0;
  int   last_valid_cyc = 0;
  logic prev_start     = 1'b0;
  logic prev_valid     = 1'b0;
  int   m_idx          = 0;
  int   m_cnt          = 0;
  int   nack_lo        = 0;
  int   nack_hi        = 0;
  int   stub_idx       = -1;

  i2c_sensor_poller #(.PERIOD(16'd100)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .i2c_ready     (m_ready),
    .i2c_ack       (m_ack),
    .i2c_read_data (rd_val),
    .i2c_start     (i2c_start),
    .i2c_addr      (i2c_addr),
    .i2c_data      (i2c_data),
    .i2c_rw        (i2c_rw),
    .i2c_two_bytes (i2c_two_bytes),
    .sample        (sample),
    .sample_valid  (sample_valid),
    .fault         (fault),
    .nack_count    (nack_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Master model: busy for 5 cycles after a start; start index selects NACK or no response.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_cnt   <= 0;
      m_ack   <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ready <= 1'b1;
    end else if (i2c_start) begin
      m_idx <= m_idx + 1;
      if (m_idx != stub_idx) begin
        m_ready <= 1'b0;
        m_cnt   <= 5;
        m_ack   <= !((m_idx >= nack_lo) && (m_idx < nack_hi));
      end
    end
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    chk_t c;
    if (rst_n) begin
      if (i2c_start) begin
        n_starts++;
        last_start_cyc = cyc;
        compare("start_single_cycle", {31'd0, prev_start}, 32'd0);
        if (exp_txn.size() == 0)
          compare("unexpected_start", {7'd0, i2c_addr, i2c_rw, i2c_two_bytes, i2c_data}, 32'hFFFF_FFFF);
        else
          compare("txn_operands", {7'd0, i2c_addr, i2c_rw, i2c_two_bytes, i2c_data}, exp_txn.pop_front());
      end
      if (sample_valid) begin
        n_samples++;
        last_valid_cyc = cyc;
        compare("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
        if (exp_sample.size() == 0)
          compare("unexpected_sample", {16'd0, sample}, 32'hFFFF_FFFF);
        else
          compare("sample_value", {16'd0, sample}, {16'd0, exp_sample.pop_front()});
      end
    end
    prev_start = rst_n && i2c_start;
    prev_valid = rst_n && sample_valid;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      compare(c.name, c.act, c.exp);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int k = 0;
    while ((n_starts < target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (n_starts < target) check(name, n_starts, target);
  endtask

  task automatic wait_samples(input int target, input int budget, input string name);
    int k = 0;
    while ((n_samples < target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (n_samples < target) check(name, n_samples, target);
  endtask

  task automatic wait_fault(input int budget, input string name);
    int k = 0;
    while (!fault && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (!fault) check(name, 32'(fault), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    enable = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop_in_sleep();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int s0, v0, a0, b0, en_cyc;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_start",     32'(i2c_start),     32'd0);
    check("rst_data",      32'(i2c_data),      32'd0);
    check("rst_rw",        32'(i2c_rw),        32'd0);
    check("rst_two_bytes", 32'(i2c_two_bytes), 32'd0);
    check("rst_sample",    32'(sample),        32'd0);
    check("rst_valid",     32'(sample_valid),  32'd0);
    check("rst_fault",     32'(fault),         32'd0);
    check("rst_nack",      32'(nack_count),    32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal: CFG, PTR, RD, sleep, PTR, RD
    exp_txn.push_back(CFG_T); exp_txn.push_back(PTR_T); exp_txn.push_back(RD_T);
    exp_txn.push_back(PTR_T); exp_txn.push_back(RD_T);
    exp_sample.push_back(16'h1A2B); exp_sample.push_back(16'h1A2B);
    s0 = n_starts; v0 = n_samples;
    en_cyc = cyc;
    enable = 1'b1;
    wait_starts(s0 + 1, 20, "wait_first_start");
    check("start_latency", last_start_cyc - en_cyc, 32'd2);
    wait_samples(v0 + 1, 200, "wait_nominal_sample1");
    a0 = last_valid_cyc;
    wait_starts(s0 + 4, 400, "wait_nominal_ptr2");
    check("sleep_gap_ge_101", 32'((last_start_cyc - a0) >= 101), 32'd1);
    wait_samples(v0 + 2, 200, "wait_nominal_sample2");
    stop_in_sleep();
    check("nominal_disable_busy", 32'(busy), 32'd0);
    check("nominal_nack", 32'(nack_count), 32'd0);

    // First RD NACKed once, then retried
    nack_lo = m_idx + 2; nack_hi = m_idx + 3;
    exp_txn.push_back(CFG_T); exp_txn.push_back(PTR_T); exp_txn.push_back(RD_T); exp_txn.push_back(RD_T);
    exp_sample.push_back(16'h1A2B);
    s0 = n_starts; v0 = n_samples;
    enable = 1'b1;
    wait_samples(v0 + 1, 300, "wait_rd_retry_sample");
    check("rd_nack_count", 32'(nack_count), 32'd1);
    check("rd_retries_cleared", 32'(dut.r_retries), 32'd0);
    check("rd_retry_starts", n_starts - s0, 32'd4);
    stop_in_sleep();
    nack_hi = 0;

    // Slave never ACKs: 4 CFG attempts then fault
    do_reset();
    check("reset_clears_nack", 32'(nack_count), 32'd0);
    nack_lo = m_idx; nack_hi = m_idx + 1000;
    repeat (4) exp_txn.push_back(CFG_T);
    s0 = n_starts;
    enable = 1'b1;
    wait_fault(300, "wait_fault");
    repeat (50) @(negedge clk);
    check("fault_set", 32'(fault), 32'd1);
    check("fault_nack_count", 32'(nack_count), 32'd4);
    check("fault_cfg_starts", n_starts - s0, 32'd4);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("fault_cleared", 32'(fault), 32'd0);
    check("fault_idle", 32'(busy), 32'd0);
    nack_hi = 0;

    // Master never responds to the first CFG: WAIT times out and retries
    do_reset();
    stub_idx = m_idx;
    exp_txn.push_back(CFG_T); exp_txn.push_back(CFG_T); exp_txn.push_back(PTR_T); exp_txn.push_back(RD_T);
    exp_sample.push_back(16'h1A2B);
    s0 = n_starts; v0 = n_samples;
    enable = 1'b1;
    wait_starts(s0 + 1, 20, "wait_timeout_start1");
    a0 = last_start_cyc;
    wait_starts(s0 + 2, 5000, "wait_timeout_start2");
    b0 = last_start_cyc;
    check("timeout_retry_gap", b0 - a0, 32'd4096);
    wait_samples(v0 + 1, 300, "wait_timeout_sample");
    check("timeout_nack_count", 32'(nack_count), 32'd1);
    stop_in_sleep();
    stub_idx = -1;

    // enable dropped during RD_WAIT: read still completes
    do_reset();
    exp_txn.push_back(CFG_T); exp_txn.push_back(PTR_T); exp_txn.push_back(RD_T);
    exp_sample.push_back(16'h1A2B);
    s0 = n_starts; v0 = n_samples;
    enable = 1'b1;
    wait_starts(s0 + 3, 200, "wait_drop_rd_start");
    enable = 1'b0;
    wait_samples(v0 + 1, 50, "wait_drop_rd_sample");
    repeat (2) @(negedge clk);
    check("drop_rd_idle", 32'(busy), 32'd0);
    check("drop_rd_starts", n_starts - s0, 32'd3);

    // Re-enable restarts at CFG; then reset in PTR_WAIT
    rd_val = 16'hBEEF;
    exp_txn.push_back(CFG_T); exp_txn.push_back(PTR_T); exp_txn.push_back(RD_T); exp_txn.push_back(PTR_T);
    exp_sample.push_back(16'hBEEF);
    s0 = n_starts;
    enable = 1'b1;
    wait_starts(s0 + 4, 400, "wait_reenable_ptr2");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_start",  32'(i2c_start),     32'd0);
    check("async_rst_busy",   32'(busy),          32'd0);
    check("async_rst_sample", 32'(sample),        32'd0);
    check("async_rst_valid",  32'(sample_valid),  32'd0);
    check("async_rst_data",   32'(i2c_data),      32'd0);
    check("async_rst_rw",     32'(i2c_rw),        32'd0);
    check("async_rst_two",    32'(i2c_two_bytes), 32'd0);
    exp_txn.push_back(CFG_T); exp_txn.push_back(PTR_T); exp_txn.push_back(RD_T);
    exp_sample.push_back(16'hBEEF);
    @(negedge clk);
    s0 = n_starts; v0 = n_samples;
    rst_n = 1'b1;
    wait_samples(v0 + 1, 300, "wait_post_reset_sample");
    check("post_reset_starts", n_starts - s0, 32'd3);
    stop_in_sleep();

    check("txn_queue_drained", exp_txn.size(), 32'd0);
    check("sample_queue_drained", exp_sample.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
